// File: rtl/lsu_dmem_port_if.sv
// Core-side request/response bundle for the load/store unit.
// master = execute stage, slave = lsu_dmem_port.
interface lsu_dmem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_is_load;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_is_load
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_is_load
  );
endinterface

// File: rtl/lsu_dmem_port.sv
// Load/store unit front end for the byte-addressed data memory:
// store lane/enable generation, load extraction/extension, access checks,
// and a single registered response slot with backpressure.
module lsu_dmem_port #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic               clk,
  input  logic               rst,
  lsu_dmem_port_if.slave     bus,
  output logic [31:0]        mem_wr_addr,
  output logic [31:0]        mem_wr_data,
  output logic [3:0]         mem_wr_en,
  output logic [31:0]        mem_rd_addr,
  input  logic [31:0]        mem_rd_data
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state, state_next;
  logic        accept;
  logic [2:0]  size;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        err;
  logic [31:0] lane;
  logic [31:0] load_data;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        is_load_q;

  assign accept = bus.req_valid && bus.req_ready;

  // Access checks: width decode, alignment and range against memory size.
  always_comb begin
    size       = 3'd0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b100: size = 3'd1;
      3'b001, 3'b101: begin
        size       = 3'd2;
        misaligned = bus.req_addr[0];
      end
      3'b010: begin
        size       = 3'd4;
        misaligned = |bus.req_addr[1:0];
      end
      default: illegal = 1'b1;
    endcase
    if (bus.req_we && bus.req_funct3[2])
      illegal = 1'b1;
  end

  // Compare addr + size > MEM_BYTES in 33 bits so high addresses cannot wrap.
  assign out_of_range = ({1'b0, bus.req_addr} + 33'(size)) > 33'(MEM_BYTES);
  assign err          = illegal || misaligned || out_of_range;

  assign mem_rd_addr = {bus.req_addr[31:2], 2'b00};
  assign mem_wr_addr = {bus.req_addr[31:2], 2'b00};

  // Store path: replicate data across lanes, enable only the addressed bytes.
  always_comb begin
    mem_wr_en   = '0;
    mem_wr_data = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00:   mem_wr_data = {4{bus.req_wdata[7:0]}};
      2'b01:   mem_wr_data = {2{bus.req_wdata[15:0]}};
      default: mem_wr_data = bus.req_wdata;
    endcase
    if (accept && bus.req_we && !err) begin
      case (bus.req_funct3[1:0])
        2'b00:   mem_wr_en = 4'b0001 << bus.req_addr[1:0];
        2'b01:   mem_wr_en = 4'b0011 << bus.req_addr[1:0];
        default: mem_wr_en = 4'b1111;
      endcase
    end
  end

  // Load path: shift addressed bytes down, then sign/zero-extend.
  always_comb begin
    lane = mem_rd_data >> {bus.req_addr[1:0], 3'b000};
    case (bus.req_funct3)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      3'b010:  load_data = mem_rd_data;
      default: load_data = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: any acceptance refills the slot; a drain with no refill empties it.
  always_comb begin
    state_next = state;
    if (accept)
      state_next = RESP;
    else if (state == RESP && bus.resp_ready)
      state_next = IDLE;
  end

  // Handshake outputs; req_ready is forced low during reset.
  always_comb begin
    bus.req_ready  = !rst && ((state == IDLE) || bus.resp_ready);
    bus.resp_valid = (state == RESP);
  end

  // Response payload registers, loaded only on acceptance so a stalled response holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      err_q     <= 1'b0;
      is_load_q <= 1'b0;
    end else if (accept) begin
      rdata_q   <= (err || bus.req_we) ? '0 : load_data;
      err_q     <= err;
      is_load_q <= !bus.req_we;
    end
  end

  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_err     = err_q;
  assign bus.resp_is_load = is_load_q;

endmodule

// File: doc/lsu_dmem_port.md
Name: lsu_dmem_port

Overview:
Load/store unit that issues requests to the team's byte-addressed data memory. The data memory has a combinational 32-bit read port and a byte-enabled synchronous write port. The block sits between the core's execute stage and that memory. Per request it:
- generates word-aligned addresses, byte lanes and write enables for stores (SB/SH/SW);
- extracts and sign- or zero-extends load data (LB/LH/LW/LBU/LHU);
- flags misaligned, illegal and out-of-range accesses.
Requests use a valid/ready handshake. Responses are registered and use a valid/ready handshake with backpressure.

Parameters:
MEM_BYTES, 65536, size of the data memory in bytes; any address >= MEM_BYTES is an access fault.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal or out-of-range access
resp_is_load  out  1  echo of !req_we for the response
mem_wr_addr  out  32  to data memory write address
mem_wr_data  out  32  to data memory write data, lane-replicated
mem_wr_en  out  4  to data memory byte write enables
mem_rd_addr  out  32  to data memory read address
mem_rd_data  in  32  from data memory, combinational read data

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, resp_is_load=0. FSM goes to IDLE.
- FSM states:
  - IDLE (no response held).
  - RESP (response held).
- Handshake:
  - req_ready = (state==IDLE) || resp_ready. This allows one request per cycle while the consumer drains.
  - Acceptance = req_valid && req_ready.
  - On acceptance, the response registers load on the same edge; the FSM moves to or stays in RESP.
  - In RESP with resp_ready and no new acceptance: go to IDLE, resp_valid=0.
  - In RESP with !resp_ready: all response outputs hold stable and req_ready=0.
- Error check (combinational on the request):
  - Illegal: funct3 in {011,110,111}; or req_we with funct3[2]=1.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Out of range: addr > MEM_BYTES - size.
  - Any of the above: resp_err=1, resp_rdata=0, mem_wr_en=4'b0000. The response is still produced (1 cycle).
- Memory addressing: mem_rd_addr and mem_wr_addr are {req_addr[31:2], 2'b00}, driven combinationally from req_addr.
- Store enables, asserted only in the acceptance cycle and only when there is no error; 0 otherwise:
  - SB: mem_wr_en = 4'b0001 << addr[1:0].
  - SH: mem_wr_en = 4'b0011 << addr[1:0] (addr[1:0] is 0 or 2).
  - SW: mem_wr_en = 4'b1111.
  - Memory commits the write on the same clock edge as acceptance.
- Store data: SB replicates wdata[7:0] to all four lanes; SH replicates wdata[15:0] to both halves; SW passes wdata through.
- Load data: lane = mem_rd_data >> (8*addr[1:0]).
  - B: sign-extend bit 7. BU: zero-extend.
  - H: sign-extend bit 15. HU: zero-extend.
  - W: unmodified.
  - Result is registered into resp_rdata at acceptance; latency is 1 cycle from acceptance to resp_valid.
- Store responses: resp_rdata=0, resp_is_load=0.
- Load after store: a load accepted in the cycle after a store to the same word sees the stored data, because the write committed on the previous edge.
- Reset mid-operation: rst has priority over all other inputs. A held response is discarded and no write enable is asserted during rst=1; req_ready=0 while rst=1.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=1 -> resp_valid=0, mem_wr_en=0, req_ready=0.
- Byte store: SB addr=0x102 wdata=0x000000A5 -> mem_wr_en=4'b0100, mem_wr_addr=0x100, mem_wr_data=0xA5A5A5A5. Then LB 0x102 -> resp_rdata=0xFFFFFFA5; LBU 0x102 -> 0x000000A5, each 1 cycle after acceptance.
- Half/word: SW 0x200=0x8001_7F02, then LH 0x202 -> 0xFFFF8001, LHU 0x200 -> 0x00007F02, LW 0x200 -> 0x80017F02.
- Errors: LW 0x201 -> resp_err=1, resp_rdata=0. SH 0x203 -> resp_err=1, mem_wr_en=0 and memory unchanged. LW 0x0000FFFE with MEM_BYTES=65536 -> resp_err=1. funct3=011 -> resp_err=1.
- Backpressure: back-to-back LW 0x200 and LW 0x204 with resp_ready=0 for 3 cycles -> first response held stable, req_ready=0, second request not accepted. resp_ready=1 -> two responses on consecutive cycles, in order.
- Throughput: 8 alternating SW/LW to the same word with resp_ready=1 -> one acceptance per cycle, each LW returns the preceding SW data.
